// File: rtl/sha256_compress_iter.sv
// sha256_compress_iter
//   Iterative SHA-256 compression core. ROUNDS_PER_CYCLE rounds are chained
//   combinationally and applied once per clock. The message schedule is kept
//   as a 16-word sliding window that generates new words as it shifts.
//
//   Optional feature macro: SHA256_FEEDFORWARD_EN
//     defined   : updated_hash = prev_hash + {a..h} word-wise (chaining value)
//     undefined : updated_hash = raw {a..h}; no prev_hash hold register
//
// Parameters
//   ROUNDS_PER_CYCLE : rounds per clock, one of 1, 2, 4, 8
//   WK_LENGTH        : total rounds, fixed at 64
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   start         in   begin a block (sampled only in IDLE)
//   block_in      in   512-bit block, W0 in [511:480]
//   prev_hash     in   256-bit chaining value, a/H0 in [255:224]
//   busy          out  high from ROUND through FINAL
//   hash_complete out  one-cycle pulse with a new updated_hash
//   updated_hash  out  result, same word order as prev_hash

module sha256_compress_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int WK_LENGTH        = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] prev_hash,
  output logic         busy,
  output logic         hash_complete,
  output logic [255:0] updated_hash
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] CNT_STEP = 6'(R);
  localparam logic [5:0] CNT_LAST = 6'(WK_LENGTH - R);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic [255:0]  hash_q;
  logic [5:0]    cnt_q;
  logic [31:0]   wv_q  [8];
  logic [31:0]   win_q [16];
`ifdef SHA256_FEEDFORWARD_EN
  logic [31:0]   hold_q [8];
`endif

  logic [31:0]   ext [16+R];
  logic [31:0]   st  [R+1][8];
  logic [31:0]   t1, t2;
  logic [255:0]  result;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Schedule extension and the chained round group. ext[0..15] is the current
  // window (W[t]..W[t+15]); ext[16..15+R] are the words that enter this cycle.
  // Later extension words may depend on earlier ones of the same cycle.
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int k = 0; k < 16; k++) ext[k] = win_q[k];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 8; i++) st[0][i] = wv_q[i];
    for (int j = 0; j < R; j++) begin
      t1 = st[j][7] + bsig1(st[j][4]) + ch(st[j][4], st[j][5], st[j][6])
         + K_TAB[cnt_q + 6'(j)] + ext[j];
      t2 = bsig0(st[j][0]) + maj(st[j][0], st[j][1], st[j][2]);
      st[j+1][0] = t1 + t2;
      st[j+1][1] = st[j][0];
      st[j+1][2] = st[j][1];
      st[j+1][3] = st[j][2];
      st[j+1][4] = st[j][3] + t1;
      st[j+1][5] = st[j][4];
      st[j+1][6] = st[j][5];
      st[j+1][7] = st[j][6];
    end
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
      result[255-32*i -: 32] = hold_q[i] + wv_q[i];
`else
      result[255-32*i -: 32] = wv_q[i];
`endif
    end
  end

  // Control FSM plus the working variables, which must clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hash_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) wv_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) wv_q[i] <= prev_hash[255-32*i -: 32];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          for (int i = 0; i < 8; i++) wv_q[i] <= st[R][i];
          cnt_q <= cnt_q + CNT_STEP;
          if (cnt_q == CNT_LAST) state_q <= FINAL;
        end
        FINAL: begin
          hash_q  <= result;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Schedule window and chaining hold: pure datapath, no reset needed.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && start) begin
      for (int k = 0; k < 16; k++) win_q[k] <= block_in[511-32*k -: 32];
`ifdef SHA256_FEEDFORWARD_EN
      for (int i = 0; i < 8; i++) hold_q[i] <= prev_hash[255-32*i -: 32];
`endif
    end else if (state_q == ROUND) begin
      for (int k = 0; k < 16; k++) win_q[k] <= ext[k+R];
    end
  end

  assign busy          = busy_q;
  assign hash_complete = done_q;
  assign updated_hash  = hash_q;

endmodule

// File: tb/tb_sha256_compress_iter.sv
module tb_sha256_compress_iter;

  logic         clock;
  logic         reset;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] prev_hash;
  logic         busy1, done1, busy4, done4;
  logic [255:0] hash1, hash4;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_compress_iter #(.ROUNDS_PER_CYCLE(1), .WK_LENGTH(64)) dut1 (
    .clock(clock), .reset(reset), .start(start), .block_in(block_in),
    .prev_hash(prev_hash), .busy(busy1), .hash_complete(done1), .updated_hash(hash1));

  sha256_compress_iter #(.ROUNDS_PER_CYCLE(4), .WK_LENGTH(64)) dut4 (
    .clock(clock), .reset(reset), .start(start), .block_in(block_in),
    .prev_hash(prev_hash), .busy(busy4), .hash_complete(done4), .updated_hash(hash4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: textbook SHA-256 compression with the full 64-word schedule.
  function automatic logic [255:0] model(input logic [511:0] blk, input logic [255:0] prev);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, x1, x2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = prev[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
      r[255-32*i -: 32] = v[i] + prev[255-32*i -: 32];
`else
      r[255-32*i -: 32] = v[i];
`endif
    end
    return r;
  endfunction

  // Expected output for a single block started from the IV, given its digest.
  function automatic logic [255:0] from_digest(input logic [255:0] dig);
    logic [255:0] iv_v;
    logic [255:0] r;
    iv_v = IV;
    r = dig;
`ifndef SHA256_FEEDFORWARD_EN
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = dig[255-32*i -: 32] - iv_v[255-32*i -: 32];
`endif
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one block on both cores; returns right after the R=1 core finishes so
  // a following call lands its start on the first IDLE cycle.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] prev,
                           input logic [255:0] exp, input int spam, input string tag);
    int lat1, lat4, nd4;
    logic [255:0] h1, h4;
    lat1 = 0; lat4 = 0; nd4 = 0; h1 = '0; h4 = '0;
    @(negedge clock);
    block_in  = blk;
    prev_hash = prev;
    start     = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_busy1"}, 256'(busy1), 256'd1);
    chk({tag, "_busy4"}, 256'(busy4), 256'd1);
    block_in  = rand_block();
    prev_hash = rand_hash();
    for (int k = 1; k <= 100; k++) begin
      start = (k <= spam);
      @(posedge clock); #1;
      if (done4) begin
        nd4++;
        if (lat4 == 0) begin
          lat4 = k;
          h4 = hash4;
          chk({tag, "_busy4_done"}, 256'(busy4), 256'd0);
        end
      end
      if (done1) begin
        lat1 = k;
        h1 = hash1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_lat1"}, 256'(lat1), 256'd65);
    chk({tag, "_lat4"}, 256'(lat4), 256'd17);
    chk({tag, "_ndone4"}, 256'(nd4), 256'd1);
    chk({tag, "_hash1"}, h1, exp);
    chk({tag, "_hash4"}, h4, exp);
  endtask

  initial begin
    logic [511:0] abc_blk, empty_blk, b1, b2, rb;
    logic [255:0] h1_exp, h2_exp, rp;
    string s;

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    empty_blk = '0;
    empty_blk[511:480] = 32'h80000000;
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    b1 = '0;
    for (int i = 0; i < 56; i++) b1[511-8*i -: 8] = s[i];
    b1[511-8*56 -: 8] = 8'h80;
    b2 = '0;
    b2[31:0] = 32'd448;

    reset = 1'b1; start = 1'b0; block_in = '0; prev_hash = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy1", 256'(busy1), 256'd0);
    chk("rst_done1", 256'(done1), 256'd0);
    chk("rst_hash1", hash1, 256'd0);
    chk("rst_busy4", 256'(busy4), 256'd0);
    chk("rst_done4", 256'(done4), 256'd0);
    chk("rst_hash4", hash4, 256'd0);
    @(negedge clock);
    reset = 1'b0;

    run_block(abc_blk, IV, from_digest(ABC_DIG), 0, "abc");
    run_block(empty_blk, IV, from_digest(EMPTY_DIG), 0, "empty");

    // Two-block message, second block started on the first IDLE cycle.
    h1_exp = model(b1, IV);
`ifdef SHA256_FEEDFORWARD_EN
    h2_exp = TWO_DIG;
`else
    h2_exp = model(b2, h1_exp);
`endif
    run_block(b1, IV, h1_exp, 0, "two_b1");
    run_block(b2, h1_exp, h2_exp, 0, "two_b2");

    // Result must hold while idle.
    repeat (5) @(posedge clock);
    #1;
    chk("hold_hash1", hash1, h2_exp);
    chk("hold_done1", 256'(done1), 256'd0);
    chk("hold_busy1", 256'(busy1), 256'd0);

    // Reset mid-block abandons it.
    @(negedge clock);
    block_in = abc_blk; prev_hash = IV; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_busy1", 256'(busy1), 256'd0);
    chk("midrst_done1", 256'(done1), 256'd0);
    chk("midrst_hash1", hash1, 256'd0);
    chk("midrst_hash4", hash4, 256'd0);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("midrst_nodone1", 256'(done1), 256'd0);
    chk("midrst_idle1", 256'(busy1), 256'd0);
    chk("midrst_hold1", hash1, 256'd0);
    run_block(abc_blk, IV, from_digest(ABC_DIG), 0, "abc_after_rst");

    // start held high through the R=4 core's ROUND and FINAL cycles.
    run_block(abc_blk, IV, from_digest(ABC_DIG), 17, "spam");

    for (int n = 0; n < 3; n++) begin
      rb = rand_block();
      rp = rand_hash();
      run_block(rb, rp, model(rb, rp), 0, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
